qspi_flash_rd_seq: RTL
======================

# qspi_flash_rd_seq

Upstream sequencer that turns one flash read request (24-bit byte address, length) into the ordered series of register accesses on the QSPI wrapper's 3-bit register port. The series drives chip-select low, sends the read command and address, reads N data bytes and releases chip-select. It sits between a system read master and the QSPI register wrapper, issues exactly one outstanding register access at a time, and streams read bytes out with valid/ready flow control.

## Interface
Parameters:
- DIV, 4'd2, SCK divider written to config1[7:4]
- MODE, 2'd0, SPI mode written to config0[7:6]
- FAST_RD, 0, 0: command 0x03 and no dummy byte; 1: command 0x0B plus one dummy byte 0x00

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- rd_req_vld  in  1  read request valid
- rd_req_rdy  out  1  request accepted; high only in IDLE
- rd_req_addr  in  24  flash byte address
- rd_req_len  in  8  byte count; 0 encodes 256
- rd_dat_vld  out  1  read byte valid
- rd_dat_rdy  in  1  downstream ready
- rd_dat  out  8  read byte
- rd_dat_last  out  1  final byte of request
- busy  out  1  sequence in progress (not IDLE)
- qspi_if_req_vld  out  1  register access valid
- qspi_if_req_rdy  in  1  register access accepted
- qspi_if_req_addr  out  3  0=config0, 1=config1, 2=data
- qspi_if_req_read  out  1  1=read access
- qspi_if_req_dat  out  8  write data
- qspi_if_rsp_vld  in  1  response valid
- qspi_if_rsp_rdy  out  1  response accept
- qspi_if_rsp_dat  in  8  response data

## Operation
- Top states: IDLE, REQ (qspi_if_req_vld=1, hold until req handshake), RSP (wait rsp handshake). Phase register selects the access.
- Phases in order, with (addr, read, dat):
  - CFG0: (0, 0, {MODE,6'b0})
  - CSL: (1, 0, {DIV,1'b0,3'b0})
  - CMD: (2, 0, FAST_RD?0x0B:0x03)
  - A2, A1, A0: (2, 0, addr[23:16] / [15:8] / [7:0])
  - DMY: (2, 0, 0x00), only when FAST_RD=1
  - DAT: (2, 1, 0x00), repeated len times
  - CSH: (1, 0, {DIV,1'b1,3'b0})
  - then IDLE
- On rd_req handshake in IDLE: latch addr and len into 9-bit remaining count (len=0 gives 256), enter CFG0/REQ.
- REQ to RSP on qspi_if_req_vld & qspi_if_req_rdy. Outputs are held stable while vld=1 and rdy=0.
- RSP in write phases: qspi_if_rsp_rdy=1. The first cycle with rsp_vld=1 advances to the next phase's REQ.
- RSP in DAT: rd_dat_vld=qspi_if_rsp_vld, rd_dat=qspi_if_rsp_dat, qspi_if_rsp_rdy=rd_dat_rdy. On handshake, decrement count. rd_dat_last=1 when count==1. At count 1 go to CSH, otherwise repeat DAT.
- Responses arriving outside RSP are ignored (rsp_rdy=0). Exactly one response is consumed per access.
- No new rd_req is accepted until CSH response completes.

## Timing
- Reset values: rd_req_rdy=1, busy=0, qspi_if_req_vld=0, qspi_if_rsp_rdy=0, rd_dat_vld=0, rd_dat_last=0, rd_dat=0, qspi_if_req_addr/read/dat=0. State is IDLE and count is 0.
- rd_req handshake at cycle N gives qspi_if_req_vld=1 at N+1.
- A response handshake at cycle M gives the next access's req_vld=1 at M+1. There is no bubble beyond one cycle.
- With a zero-wait target, the minimum gap between consecutive accesses is 2 cycles (REQ + RSP).
- rd_dat path is combinational from qspi_if_rsp_* in DAT/RSP. No added latency.
- The final CSH response handshake at cycle K gives rd_req_rdy=1 and busy=0 at K+1.
- Reset mid-sequence: return to IDLE immediately, dropping all vld outputs. No CS-high access is issued; the register target is reset by the same rst_n.

## Test plan
- FAST_RD=0, addr 0x123456, len 1, zero-wait target returning 0xA5 -> exact access list (0,W,0x00),(1,W,0x20),(2,W,0x03),(2,W,0x12),(2,W,0x34),(2,W,0x56),(2,R),(1,W,0x28). Output is a single rd_dat 0xA5 with last=1. rd_req_rdy returns 1 the cycle after the final response.
- len=0 -> 256 DAT reads. rd_dat_last is asserted only on the 256th byte, then CSH is issued.
- FAST_RD=1, len 2 -> CMD byte 0x0B, one extra (2,W,0x00) before the reads, 2 bytes out.
- Random qspi_if_req_rdy stalls plus rd_dat_rdy low for 5 cycles mid-data -> request fields stable while stalled. No byte is lost or duplicated, and rsp_rdy mirrors rd_dat_rdy.
- Target holding rsp_vld high continuously during write phases -> exactly one advance per access and the sequence is unchanged.
- rst_n asserted during DAT byte 3 of 8 -> all outputs at reset values the same cycle, rd_req_rdy=1 after release, and a new request runs from CFG0.

Source files
------------

// File: rtl/qspi_flash_rd_seq.sv
// Purpose: turns one flash read request into the ordered register accesses on the QSPI wrapper port.
// Latency: first access one cycle after request accept; each access takes REQ + RSP (2 cycles minimum).
// Backpressure: one access outstanding; read responses are stalled by rd_dat_rdy, requests hold while qspi_if_req_rdy is low.
module qspi_flash_rd_seq #(
    parameter logic [3:0] DIV     = 4'd2,
    parameter logic [1:0] MODE    = 2'd0,
    parameter bit         FAST_RD = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req_vld,
    output logic        rd_req_rdy,
    input  logic [23:0] rd_req_addr,
    input  logic [7:0]  rd_req_len,
    output logic        rd_dat_vld,
    input  logic        rd_dat_rdy,
    output logic [7:0]  rd_dat,
    output logic        rd_dat_last,
    output logic        busy,
    output logic        qspi_if_req_vld,
    input  logic        qspi_if_req_rdy,
    output logic [2:0]  qspi_if_req_addr,
    output logic        qspi_if_req_read,
    output logic [7:0]  qspi_if_req_dat,
    input  logic        qspi_if_rsp_vld,
    output logic        qspi_if_rsp_rdy,
    input  logic [7:0]  qspi_if_rsp_dat
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;
    typedef enum logic [3:0] {
        PH_CFG0, PH_CSL, PH_CMD, PH_A2, PH_A1, PH_A0, PH_DMY, PH_DAT, PH_CSH
    } phase_t;

    typedef struct packed {
        logic [2:0] addr;
        logic       read;
        logic [7:0] dat;
    } acc_t;

    state_t      state;
    phase_t      phase;
    phase_t      nxt_phase;
    logic [8:0]  cnt;
    logic [23:0] addr_q;
    acc_t        req_acc;
    logic        in_dat;
    logic        in_wr;
    logic        rsp_hs;

    function automatic acc_t acc_of(input phase_t ph, input logic [23:0] a);
        acc_t r;
        r = '0;
        case (ph)
            PH_CFG0: r = '{addr: 3'd0, read: 1'b0, dat: {MODE, 6'b0}};
            PH_CSL:  r = '{addr: 3'd1, read: 1'b0, dat: {DIV, 1'b0, 3'b0}};
            PH_CMD:  r = '{addr: 3'd2, read: 1'b0, dat: FAST_RD ? 8'h0B : 8'h03};
            PH_A2:   r = '{addr: 3'd2, read: 1'b0, dat: a[23:16]};
            PH_A1:   r = '{addr: 3'd2, read: 1'b0, dat: a[15:8]};
            PH_A0:   r = '{addr: 3'd2, read: 1'b0, dat: a[7:0]};
            PH_DMY:  r = '{addr: 3'd2, read: 1'b0, dat: 8'h00};
            PH_DAT:  r = '{addr: 3'd2, read: 1'b1, dat: 8'h00};
            PH_CSH:  r = '{addr: 3'd1, read: 1'b0, dat: {DIV, 1'b1, 3'b0}};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        nxt_phase = PH_CSH;
        case (phase)
            PH_CFG0: nxt_phase = PH_CSL;
            PH_CSL:  nxt_phase = PH_CMD;
            PH_CMD:  nxt_phase = PH_A2;
            PH_A2:   nxt_phase = PH_A1;
            PH_A1:   nxt_phase = PH_A0;
            PH_A0:   nxt_phase = FAST_RD ? PH_DMY : PH_DAT;
            PH_DMY:  nxt_phase = PH_DAT;
            PH_DAT:  nxt_phase = (cnt == 9'd1) ? PH_CSH : PH_DAT;
            default: nxt_phase = PH_CSH;
        endcase
    end

    // Read data bypasses the FSM so bytes stream with no added latency.
    assign in_dat          = (state == S_RSP) && (phase == PH_DAT);
    assign in_wr           = (state == S_RSP) && (phase != PH_DAT);
    assign qspi_if_rsp_rdy = in_wr | (in_dat & rd_dat_rdy);
    assign rsp_hs          = qspi_if_rsp_vld & qspi_if_rsp_rdy;
    assign rd_dat_vld      = in_dat & qspi_if_rsp_vld;
    assign rd_dat          = in_dat ? qspi_if_rsp_dat : 8'h00;
    assign rd_dat_last     = in_dat & (cnt == 9'd1);
    assign rd_req_rdy      = (state == S_IDLE);
    assign busy            = (state != S_IDLE);

    assign qspi_if_req_addr = req_acc.addr;
    assign qspi_if_req_read = req_acc.read;
    assign qspi_if_req_dat  = req_acc.dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            phase           <= PH_CFG0;
            cnt             <= '0;
            addr_q          <= '0;
            req_acc         <= '0;
            qspi_if_req_vld <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rd_req_vld) begin
                        addr_q          <= rd_req_addr;
                        cnt             <= {(rd_req_len == 8'd0), rd_req_len};
                        phase           <= PH_CFG0;
                        req_acc         <= acc_of(PH_CFG0, rd_req_addr);
                        qspi_if_req_vld <= 1'b1;
                        state           <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (qspi_if_req_rdy) begin
                        qspi_if_req_vld <= 1'b0;
                        state           <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_hs) begin
                        if (phase == PH_DAT) begin
                            cnt <= cnt - 9'd1;
                        end
                        if (phase == PH_CSH) begin
                            state <= S_IDLE;
                        end else begin
                            phase           <= nxt_phase;
                            req_acc         <= acc_of(nxt_phase, addr_q);
                            qspi_if_req_vld <= 1'b1;
                            state           <= S_REQ;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
